// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory port between the instruction fetch unit (IF,
// read-only) and the load/store unit (LS, read/write). Exactly one memory
// transaction is outstanding at a time. A three-state machine (S_IDLE,
// S_REQ, S_RESP) picks a winner, presents its request until memory grants
// it, then waits for the response and forwards it to the winner.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties (last_owner register,
//                               reset to LS so IF wins the first tie)
//                  undefined -> fixed priority, LS beats IF
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   if_req/if_addr  IF request (held until if_rvalid) and address
//   if_rvalid/rdata IF single-cycle response strobe and read data
//   ls_req/addr/wen/wdata/wmask  LS request fields
//   ls_rvalid/rdata LS response strobe (read data or write ack) and data
//   mem_req/addr/wen/wdata/wmask request to memory, fields of the owner
//   mem_gnt         memory accepts the request this cycle
//   mem_rvalid/rdata memory response strobe and read data
// -----------------------------------------------------------------------------
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic [31:0] ls_addr,
   input  logic        ls_wen,
   input  logic [31:0] ls_wdata,
   input  logic [3:0]  ls_wmask,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   state_t state_q, state_d;
   owner_t owner_q, owner_d;
   logic   mem_req_q, mem_req_d;
   owner_t winner_s;
   logic   resp_done_s;

`ifdef MEM_ARB_RR_EN
   owner_t last_owner_q, last_owner_d;

   // Round-robin pick: on a tie the requester that did not finish last wins.
   always_comb begin
      winner_s = OWN_IF;
      if (if_req && ls_req) begin
         winner_s = (last_owner_q == OWN_LS) ? OWN_IF : OWN_LS;
      end else if (ls_req) begin
         winner_s = OWN_LS;
      end else begin
         winner_s = OWN_IF;
      end
   end

   // Remember who completed most recently.
   always_comb begin
      last_owner_d = last_owner_q;
      if (resp_done_s) begin
         last_owner_d = owner_q;
      end else begin
         last_owner_d = last_owner_q;
      end
   end

   // Round-robin history register.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner_q <= OWN_LS;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`else
   // Fixed priority pick: LS beats IF.
   always_comb begin
      winner_s = OWN_IF;
      if (ls_req) begin
         winner_s = OWN_LS;
      end else begin
         winner_s = OWN_IF;
      end
   end
`endif

   // A response completes either together with the grant or later in S_RESP;
   // mem_rvalid outside those windows (e.g. in S_IDLE) is dropped.
   always_comb begin
      resp_done_s = 1'b0;
      if (state_q == S_REQ) begin
         resp_done_s = mem_gnt && mem_rvalid;
      end else if (state_q == S_RESP) begin
         resp_done_s = mem_rvalid;
      end else begin
         resp_done_s = 1'b0;
      end
   end

   // Next-state logic for the transaction sequencer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         S_IDLE: begin
            if (if_req || ls_req) begin
               owner_d = winner_s;
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (mem_gnt && mem_rvalid) begin
               state_d = S_IDLE;
            end else if (mem_gnt) begin
               state_d = S_RESP;
            end else begin
               state_d = S_REQ;
            end
         end
         S_RESP: begin
            if (mem_rvalid) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      mem_req_d = (state_d == S_REQ);
   end

   // Sequencer state, owner and registered memory request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_IF;
         mem_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         mem_req_q <= mem_req_d;
      end
   end

   // Memory-side fields follow the owner at all times; mem_wen is forced low
   // whenever no request is presented so a stale LS write never leaks out.
   always_comb begin
      if (owner_q == OWN_LS) begin
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
         mem_wmask = ls_wmask;
         mem_wen   = mem_req_q && ls_wen;
      end else begin
         mem_addr  = if_addr;
         mem_wdata = 32'h0000_0000;
         mem_wmask = 4'h0;
         mem_wen   = 1'b0;
      end
   end

   assign mem_req   = mem_req_q;
   assign if_rvalid = resp_done_s && (owner_q == OWN_IF);
   assign ls_rvalid = resp_done_s && (owner_q == OWN_LS);
   assign if_rdata  = mem_rdata;
   assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic [31:0] ls_addr;
   logic        ls_wen;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_wmask;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int tests;
   int fails;
   int cyc;

   localparam logic [31:0] KEY = 32'h5A5A_A5A5;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        rst;
      logic        ifr;
      logic [31:0] ifa;
      logic        lsr;
      logic [31:0] lsa;
      logic        lsw;
      logic [31:0] wd;
      logic [3:0]  wm;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_wen;
      logic        e_ifv;
      logic        e_lsv;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic ifr, input logic [31:0] ifa,
                               input logic lsr, input logic [31:0] lsa, input logic lsw,
                               input logic [31:0] wd, input logic [3:0] wm,
                               input logic gnt, input logic rv, input logic [31:0] rd,
                               input logic er, input logic [31:0] ea, input logic ew,
                               input logic eif, input logic els);
      vec_t v;
      v.rst = r; v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.lsa = lsa; v.lsw = lsw;
      v.wd = wd; v.wm = wm; v.gnt = gnt; v.rv = rv; v.rd = rd;
      v.e_req = er; v.e_addr = ea; v.e_wen = ew; v.e_ifv = eif; v.e_lsv = els;
      return v;
   endfunction

   task automatic drive(input logic r, input logic ifr, input logic [31:0] ifa,
                        input logic lsr, input logic [31:0] lsa, input logic lsw,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input logic gnt, input logic rv, input logic [31:0] rd);
      rst = r; if_req = ifr; if_addr = ifa; ls_req = lsr; ls_addr = lsa; ls_wen = lsw;
      ls_wdata = wd; ls_wmask = wm; mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd;
   endtask

   task automatic run_row(input vec_t v, input int idx);
      string tag;
      @(negedge clk);
      drive(v.rst, v.ifr, v.ifa, v.lsr, v.lsa, v.lsw, v.wd, v.wm, v.gnt, v.rv, v.rd);
      #1;
      tag = $sformatf("row%0d", idx);
      chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, v.e_req});
      chk({tag, ".mem_wen"}, {31'd0, mem_wen}, {31'd0, v.e_wen});
      chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, {31'd0, v.e_ifv});
      chk({tag, ".ls_rvalid"}, {31'd0, ls_rvalid}, {31'd0, v.e_lsv});
      if (v.e_req) chk({tag, ".mem_addr"}, mem_addr, v.e_addr);
      if (v.e_wen) begin
         chk({tag, ".mem_wdata"}, mem_wdata, v.wd);
         chk({tag, ".mem_wmask"}, {28'd0, mem_wmask}, {28'd0, v.wm});
      end
      if (v.e_ifv) chk({tag, ".if_rdata"}, if_rdata, v.rd);
      if (v.e_lsv) chk({tag, ".ls_rdata"}, ls_rdata, v.rd);
   endtask

   // ---------------- directed table ----------------
   task automatic build_table();
      logic [31:0] a0 = 32'h8000_0000;
      logic [31:0] la = 32'h8000_1000;
      logic [31:0] ab = 32'h8000_0200;
      logic [31:0] lb = 32'h8000_3000;
      logic [31:0] ad = 32'h8000_0300;
      logic [31:0] ac = 32'h8000_0400;
      // reset state
      tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      // single IF read, gnt+rvalid together
      tbl.push_back(mk(1'b0, 1'b1, a0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, a0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b1, 32'h0000_0413, 1'b1, a0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, a0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      // LS write, gnt at 1, rvalid at 4
      tbl.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, la, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, la, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'd0, 1'b1, la, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, la, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, la, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, la, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, la, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
`ifndef MEM_ARB_RR_EN
      // simultaneous requests, fixed priority: LS first, IF two cycles later
      tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_2000, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_2000, 1'b0, 32'd0, 4'h0, 1'b1, 1'b1, 32'hAAAA_0001, 1'b1, 32'h8000_2000, 1'b0, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_2000, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_2000, 1'b0, 32'd0, 4'h0, 1'b1, 1'b1, 32'hAAAA_0002, 1'b1, 32'h8000_0100, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_2000, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
`endif
      // gnt backpressure; LS arrives but IF keeps ownership
      tbl.push_back(mk(1'b0, 1'b1, ab, 1'b0, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, ab, 1'b0, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b1, 32'd0, 1'b1, ab, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, ab, 1'b1, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b0, 32'd0, 1'b1, ab, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, ab, 1'b1, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b0, 32'd0, 1'b1, ab, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, ab, 1'b1, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b1, 1'b1, 32'h0000_0777, 1'b1, ab, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, ab, 1'b1, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, ab, 1'b1, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b1, 1'b1, 32'd0, 1'b1, lb, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, ab, 1'b0, lb, 1'b1, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      // IF drops req mid-transaction: still completes and pulses
      tbl.push_back(mk(1'b0, 1'b1, ac, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, ac, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b1, ac, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, ac, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b1, 32'h0000_0999, 1'b1, ac, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, ac, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      // reset in S_RESP, late mem_rvalid discarded
      tbl.push_back(mk(1'b0, 1'b1, ad, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, ad, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b0, 32'd0, 1'b1, ad, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, ad, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, ad, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b1, 32'h0000_0555, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, ad, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
   endtask

   // ---------------- repeated ties ----------------
   task automatic tie_sequence();
      int got[4];
      int exp_order[4];
      int n = 0;
`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{1, 1, 1, 1};
`endif
      @(negedge clk);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 32'h8000_0A00, 1'b1, 32'h8000_0B00, 1'b0, 32'd0, 4'h0,
               mem_req, mem_req, $urandom);
         #1;
         if (mem_req) begin
            got[n] = (mem_addr == 32'h8000_0B00) ? 1 : 0;
            n++;
         end
      end
      if (n < 4) begin
         tests++;
         fails++;
         $display("FAIL tie_timeout got=%0d transactions expected=4", n);
      end else begin
         for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), got[i], exp_order[i]);
      end
   endtask

   // ---------------- randomized run vs transaction-level model ----------------
   task automatic random_run();
      // requester side
      logic        rq[2];
      logic [31:0] ra[2];
      logic        rw[2];
      logic [31:0] rd_w[2];
      logic [3:0]  rm[2];
      // memory side
      logic        mbusy = 1'b0;
      int          mdly = 0;
      logic [31:0] macc = 32'd0;
      // model: stage 0 = no transaction, 1 = asking memory, 2 = awaiting data
      int          stage = 0;
      int          who = 0;
      int          last = 1;
      logic        r_rst, g, v, e_done;
      logic [31:0] d;
      for (int r = 0; r < 2; r++) begin
         rq[r] = 1'b0; ra[r] = 32'd0; rw[r] = 1'b0; rd_w[r] = 32'd0; rm[r] = 4'h0;
      end
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         r_rst = (c < 2) || ($urandom_range(0, 199) == 0);
         for (int r = 0; r < 2; r++) begin
            if (!rq[r] && $urandom_range(0, 99) < 30) begin
               rq[r] = 1'b1;
               ra[r] = $urandom;
               rw[r] = (r == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
               rd_w[r] = $urandom;
               rm[r] = 4'($urandom_range(0, 15));
            end
         end
         g = 1'b0; v = 1'b0; d = $urandom;
         if (mbusy) begin
            if (mdly == 0) begin
               v = 1'b1; d = macc ^ KEY; mbusy = 1'b0;
            end else begin
               mdly--;
            end
         end else if (mem_req) begin
            if ($urandom_range(0, 99) < 60) begin
               g = 1'b1; macc = mem_addr;
               if ($urandom_range(0, 1) == 0) begin
                  v = 1'b1; d = macc ^ KEY;
               end else begin
                  mbusy = 1'b1; mdly = $urandom_range(0, 3);
               end
            end
         end else if ($urandom_range(0, 99) < 8) begin
            v = 1'b1;
         end
         if (r_rst) mbusy = 1'b0;
         drive(r_rst, rq[0], ra[0], rq[1], ra[1], rw[1], rd_w[1], rm[1], g, v, d);
         #1;
         e_done = (stage == 1 && g && v) || (stage == 2 && v);
         chk("rnd.mem_req", {31'd0, mem_req}, {31'd0, (stage == 1)});
         if (stage == 1) begin
            chk("rnd.mem_addr", mem_addr, ra[who]);
            chk("rnd.mem_wen", {31'd0, mem_wen}, {31'd0, rw[who]});
            if (rw[who]) begin
               chk("rnd.mem_wdata", mem_wdata, rd_w[who]);
               chk("rnd.mem_wmask", {28'd0, mem_wmask}, {28'd0, rm[who]});
            end
         end else begin
            chk("rnd.mem_wen_idle", {31'd0, mem_wen}, 32'd0);
         end
         chk("rnd.if_rvalid", {31'd0, if_rvalid}, {31'd0, (e_done && who == 0)});
         chk("rnd.ls_rvalid", {31'd0, ls_rvalid}, {31'd0, (e_done && who == 1)});
         if (e_done) chk("rnd.rdata", (who == 0) ? if_rdata : ls_rdata, ra[who] ^ KEY);
         // advance the model with this cycle's inputs
         if (r_rst) begin
            stage = 0; who = 0; last = 1;
         end else if (stage == 0) begin
            if (rq[0] || rq[1]) begin
`ifdef MEM_ARB_RR_EN
               if (rq[0] && rq[1]) who = (last == 1) ? 0 : 1;
               else who = rq[1] ? 1 : 0;
`else
               who = rq[1] ? 1 : 0;
`endif
               stage = 1;
            end
         end else if (e_done) begin
            stage = 0; last = who;
         end else if (stage == 1 && g) begin
            stage = 2;
         end
         // requesters: after a response either drop or re-request
         if (e_done && !r_rst) begin
            if ($urandom_range(0, 99) < 80) begin
               rq[who] = 1'b0;
            end else begin
               ra[who] = $urandom;
               rd_w[who] = $urandom;
            end
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc = 0;
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);
      build_table();
      for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);
      tie_sequence();
      random_run();
      @(negedge clk);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter for the multi-cycle core. It shares the single memory port between the instruction fetch unit (IF, read-only) and the load/store unit (LS, read/write). The block sits between those units and the memory model/bus bridge and serialises accesses with exactly one transaction outstanding. Arbitration is fixed-priority by default, or round-robin when enabled at build time.

## Interface
Parameters:
- none (addresses and data are 32 bits; the write mask is 4 bits)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  IF request; held high until if_rvalid
- if_addr  in  32  IF address; stable while if_req is high
- if_rvalid  out  1  single-cycle IF response strobe
- if_rdata  out  32  IF read data; valid with if_rvalid
- ls_req  in  1  LS request; held high until ls_rvalid
- ls_addr  in  32  LS address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  32  write data
- ls_wmask  in  4  byte enables
- ls_rvalid  out  1  LS response strobe; read data or write acknowledge
- ls_rdata  out  32  LS read data; don't-care for writes
- mem_req  out  1  request to memory
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  32/1/32/4  fields of the granted requester
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response strobe
- mem_rdata  in  32  memory read data

## Operation
- State machine: S_IDLE, S_REQ, S_RESP. The owner register holds IF or LS.
- S_IDLE:
  - If any request is high, latch the arbitration winner into owner and go to S_REQ.
  - Otherwise stay in S_IDLE.
- S_REQ:
  - mem_req=1; the mem_* fields are muxed from the owner's inputs.
  - mem_gnt && mem_rvalid: forward the response and go to S_IDLE.
  - mem_gnt only: go to S_RESP.
  - Neither: hold.
- S_RESP:
  - mem_req=0.
  - On mem_rvalid, forward the response and go to S_IDLE.
- Response forwarding:
  - The owner's rvalid = mem_rvalid, combinational passthrough, only in S_REQ (gated by mem_gnt) and S_RESP.
  - The owner's rdata = mem_rdata. The non-owner's rvalid stays 0.
- The memory-side fields are driven from the owner even outside S_REQ. When mem_req=0 they are don't-care, but mem_wen must be 0.
- Default priority is fixed: LS beats IF on simultaneous requests.
- A requester that drops its req mid-transaction is ignored. The transaction completes and rvalid still pulses.
- mem_rvalid in S_IDLE is ignored.

## Timing
- Reset values: state=S_IDLE, owner=IF, mem_req=0, mem_wen=0, if_rvalid=0, ls_rvalid=0. The rdata outputs follow mem_rdata.
- Arbitration latency is 1 cycle: a request seen in S_IDLE at cycle N gives mem_req=1 at cycle N+1.
- Minimum round trip: req at N; gnt+rvalid at N+1; rvalid to the requester at N+1. Next arbitration happens at N+2.
- Requesters must deassert req in the cycle after their rvalid. Otherwise they are re-arbitrated.
- Back-to-back: the other requester, if pending, is granted at N+2 (one idle cycle between transactions).
- Reset mid-transaction: state goes to S_IDLE at the next edge and mem_req drops. A late mem_rvalid is discarded (ignored in S_IDLE).
- Never more than one outstanding memory transaction.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration using a last_owner register, reset to LS so IF wins the first tie.
  - On a tie, grant the requester not equal to last_owner.
  - last_owner updates when a response completes.
- Not defined: fixed LS > IF priority, and no last_owner register.

## Test plan
- Single IF read: if_req=1, if_addr=0x80000000; memory gnt+rvalid at the next cycle with rdata=0x00000413 -> mem_addr=0x80000000, mem_wen=0, if_rvalid pulses once with if_rdata=0x00000413, ls_rvalid=0.
- LS write with a delayed response: ls_wen=1, ls_addr=0x80001000, ls_wdata=0xDEADBEEF, wmask=0xF; gnt at cycle 1, rvalid at cycle 4 -> mem fields match for the full S_REQ; ls_rvalid pulses only at cycle 4; mem_req=0 in cycles 2-4.
- Simultaneous requests, fixed priority: if_req=ls_req=1 at cycle 0 -> LS granted first (mem_addr=ls_addr). IF is granted at cycle 2 after an LS response at cycle 1.
- Simultaneous requests, MEM_ARB_RR_EN: repeated ties over 4 transactions -> grant order IF, LS, IF, LS.
- Gnt backpressure: mem_gnt=0 for 3 cycles -> mem_req and mem_addr are held stable, and the owner does not change even if the other requester arrives.
- Reset mid-transaction: rst pulsed in S_RESP, then mem_rvalid=1 the cycle after reset deasserts -> no if_rvalid/ls_rvalid pulse, state S_IDLE, mem_req=0.
